// File: rtl/led_pkg.sv
// led_pkg: shared types and reset constants for the LED driver.
//   led_mode_e   - per-channel run-time mode
//   LED_MODE_RST - mode every channel wakes up in
//   LED_DUTY_RST - duty every channel wakes up with
//   clog2_min1   - $clog2 clamped to at least 1 bit
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } led_mode_e;

  // ON out of reset so the block behaves as "LED follows sel".
  localparam led_mode_e   LED_MODE_RST = MODE_ON;
  localparam int unsigned LED_DUTY_RST = 0;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: shared time base for all LED channels.
//   clk, rst_n  - clock, async active-low reset
//   tick_int    - registered one-cycle tick, every DIV clocks
//   blink_phase - toggles every BLINK_TICKS ticks
//   pwm_cnt     - free-running PWM_BITS counter, advances per tick
// All counters step on the same edge that raises tick_int, so blink_phase
// and pwm_cnt change together with the visible tick.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int unsigned DIV         = 100000,
  parameter int unsigned BLINK_TICKS = 8,
  parameter int unsigned PWM_BITS    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                tick_int,
  output logic                blink_phase,
  output logic [PWM_BITS-1:0] pwm_cnt
);

  localparam int unsigned DIV_W = clog2_min1(DIV);
  localparam int unsigned BLK_W = clog2_min1(BLINK_TICKS);

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [BLK_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                tick_q;
  logic                div_wrap, blink_wrap;

  always_comb begin
    div_wrap    = (div_cnt_q == DIV_W'(DIV - 1));
    blink_wrap  = (blink_cnt_q == BLK_W'(BLINK_TICKS - 1));
    div_cnt_d   = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    pwm_cnt_d   = pwm_cnt_q;
    if (div_wrap) begin
      blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + BLK_W'(1);
      phase_d     = blink_wrap ? ~phase_q : phase_q;
      pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);  // wraps naturally
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q   <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      pwm_cnt_q   <= '0;
      tick_q      <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      pwm_cnt_q   <= pwm_cnt_d;
      tick_q      <= div_wrap;
    end
  end

  assign tick_int    = tick_q;
  assign blink_phase = phase_q;
  assign pwm_cnt     = pwm_cnt_q;

endmodule

// File: rtl/led_ctrl.sv
// led_ctrl: NUM_LEDS-channel LED driver with OFF/ON/BLINK/PWM modes.
//   clk, rst_n - clock, async active-low reset
//   sel        - per-channel gate, led[i] = sel[i] & pattern[i]
//   cfg_we     - one-cycle config write strobe
//   cfg_idx    - channel to write
//   cfg_mode   - new mode (led_mode_e)
//   cfg_duty   - new PWM duty
//   cfg_err    - one-cycle pulse after a write with cfg_idx >= NUM_LEDS
//   tick       - registered time-base tick
//   led        - registered LED drive, active high
module led_ctrl
  import led_pkg::*;
#(
  parameter  int unsigned NUM_LEDS    = 3,
  parameter  int unsigned DIV         = 100000,
  parameter  int unsigned BLINK_TICKS = 8,
  parameter  int unsigned PWM_BITS    = 4,
  localparam int unsigned IDX_W       = clog2_min1(NUM_LEDS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_LEDS-1:0] sel,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic                cfg_err,
  output logic                tick,
  output logic [NUM_LEDS-1:0] led
);

  logic                tick_int;
  logic                blink_phase;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [NUM_LEDS-1:0] pattern;
  logic [NUM_LEDS-1:0] led_q;
  logic                cfg_err_q;
  logic                idx_bad;

  led_tick_gen #(
    .DIV         (DIV),
    .BLINK_TICKS (BLINK_TICKS),
    .PWM_BITS    (PWM_BITS)
  ) u_tick_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_int    (tick_int),
    .blink_phase (blink_phase),
    .pwm_cnt     (pwm_cnt)
  );

  assign idx_bad = (32'(cfg_idx) >= 32'(NUM_LEDS));

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_mode_e           mode_q, mode_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                pat;

    // Out-of-range indices never match any channel, so a bad write is a no-op.
    always_comb begin
      mode_d = mode_q;
      duty_d = duty_q;
      if (cfg_we && (32'(cfg_idx) == 32'(i))) begin
        mode_d = led_mode_e'(cfg_mode);
        duty_d = cfg_duty;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mode_q <= LED_MODE_RST;
        duty_q <= PWM_BITS'(LED_DUTY_RST);
      end else begin
        mode_q <= mode_d;
        duty_q <= duty_d;
      end
    end

    always_comb begin
      pat = 1'b0;
      case (mode_q)
        MODE_OFF:   pat = 1'b0;
        MODE_ON:    pat = 1'b1;
        MODE_BLINK: pat = blink_phase;
        MODE_PWM:   pat = (pwm_cnt < duty_q);
        default:    pat = 1'b0;
      endcase
    end

    assign pattern[i] = pat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      led_q     <= sel & pattern;
      cfg_err_q <= cfg_we & idx_bad;
    end
  end

  assign led     = led_q;
  assign cfg_err = cfg_err_q;
  assign tick    = tick_int;

endmodule

// File: tb/tb_led_ctrl.sv
// Directed bench for led_ctrl with NUM_LEDS=3, DIV=4, BLINK_TICKS=2,
// PWM_BITS=2. Cycle c is the interval right after rising edge c following
// reset release; counters step on edges that are multiples of 4.
module tb_led_ctrl;
  import led_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] sel = '0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic [1:0] cfg_mode = '0;
  logic [1:0] cfg_duty = '0;
  logic       cfg_err, tick;
  logic [2:0] led;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  led_ctrl #(
    .NUM_LEDS(3), .DIV(4), .BLINK_TICKS(2), .PWM_BITS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_mode(cfg_mode), .cfg_duty(cfg_duty), .cfg_err(cfg_err),
    .tick(tick), .led(led)
  );

  // led in cycle c reflects counters after edge c-1: tick count (c-1)/4.
  function automatic logic blink_at(input int c);
    return (((c - 1) / 4 / 2) % 2) != 0;
  endfunction

  function automatic logic pwm_at(input int c, input int d);
    return (((c - 1) / 4) % 4) < d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    cfg_we = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic cfg_write(input logic [1:0] idx, input led_mode_e m, input logic [1:0] d);
    cfg_we   = 1'b1;
    cfg_idx  = idx;
    cfg_mode = m;
    cfg_duty = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    logic et;
    rst_n = 1'b0;
    sel   = 3'b101;
    #12;
    checks++; if (led !== 3'b000) begin errors++; $display("FAIL rst_led: got %b expected 000", led); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL rst_tick: got %b expected 0", tick); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", cfg_err); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      et = (cyc % 4 == 0);
      checks++; if (tick !== et) begin errors++; $display("FAIL rst_tick_period c%0d: got %b expected %b", cyc, tick, et); end
      if (cyc == 1) begin
        checks++; if (led !== 3'b101) begin errors++; $display("FAIL rst_follow1: got %b expected 101", led); end
        sel = 3'b010;
      end
      if (cyc == 2) begin
        checks++; if (led !== 3'b010) begin errors++; $display("FAIL rst_follow2: got %b expected 010", led); end
      end
    end
  endtask

  task automatic test_blink();
    logic [2:0] e;
    do_reset();
    sel = 3'b111;
    cfg_write(2'd1, MODE_BLINK, 2'd0);
    while (cyc < 40) begin
      step();
      e = {1'b1, blink_at(cyc), 1'b1};
      checks++; if (led !== e) begin errors++; $display("FAIL blink c%0d: got %b expected %b", cyc, led, e); end
    end
  endtask

  task automatic test_pwm();
    logic [2:0] e;
    int hi;
    do_reset();
    sel = 3'b111;
    cfg_write(2'd2, MODE_PWM, 2'd1);
    hi = 0;
    while (cyc < 33) begin
      step();
      e = {pwm_at(cyc, 1), 2'b11};
      checks++; if (led !== e) begin errors++; $display("FAIL pwm_d1 c%0d: got %b expected %b", cyc, led, e); end
      if (cyc >= 18) hi += int'(led[2]);
    end
    checks++; if (hi != 4) begin errors++; $display("FAIL pwm_d1_count: got %0d expected 4", hi); end
    cfg_write(2'd2, MODE_PWM, 2'd3);
    hi = 0;
    while (cyc < 66) begin
      step();
      e = {pwm_at(cyc, 3), 2'b11};
      checks++; if (led !== e) begin errors++; $display("FAIL pwm_d3 c%0d: got %b expected %b", cyc, led, e); end
      if (cyc >= 51) hi += int'(led[2]);
    end
    checks++; if (hi != 12) begin errors++; $display("FAIL pwm_d3_count: got %0d expected 12", hi); end
    cfg_write(2'd2, MODE_PWM, 2'd0);
    while (cyc < 83) begin
      step();
      checks++; if (led !== 3'b011) begin errors++; $display("FAIL pwm_d0 c%0d: got %b expected 011", cyc, led); end
    end
  endtask

  task automatic test_err_off();
    do_reset();
    sel = 3'b111;
    step();
    checks++; if (led !== 3'b111) begin errors++; $display("FAIL err_pre: got %b expected 111", led); end
    cfg_write(2'd3, MODE_OFF, 2'd0);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_pulse: got %b expected 1", cfg_err); end
    step();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", cfg_err); end
    checks++; if (led !== 3'b111) begin errors++; $display("FAIL err_nochange: got %b expected 111", led); end
    cfg_we = 1'b1; cfg_idx = 2'd3; cfg_mode = MODE_OFF;
    step();
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_b2b1: got %b expected 1", cfg_err); end
    step();
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_b2b2: got %b expected 1", cfg_err); end
    cfg_we = 1'b0;
    step();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_b2b_end: got %b expected 0", cfg_err); end
    checks++; if (led !== 3'b111) begin errors++; $display("FAIL err_b2b_led: got %b expected 111", led); end
    cfg_write(2'd0, MODE_OFF, 2'd0);
    checks++; if (led !== 3'b111) begin errors++; $display("FAIL off_lat1: got %b expected 111", led); end
    step();
    checks++; if (led !== 3'b110) begin errors++; $display("FAIL off_lat2: got %b expected 110", led); end
    step();
    checks++; if (led !== 3'b110) begin errors++; $display("FAIL off_hold: got %b expected 110", led); end
  endtask

  task automatic test_gate_simul();
    logic et;
    logic [2:0] e;
    do_reset();
    sel = 3'b101;
    cfg_write(2'd1, MODE_BLINK, 2'd0);
    while (cyc < 7) begin
      step();
      et = (cyc % 4 == 0);
      checks++; if (led !== 3'b101) begin errors++; $display("FAIL gate c%0d: got %b expected 101", cyc, led); end
      checks++; if (tick !== et) begin errors++; $display("FAIL gate_tick c%0d: got %b expected %b", cyc, tick, et); end
    end
    // This write lands on the same edge that raises tick.
    cfg_write(2'd0, MODE_OFF, 2'd0);
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL simul_tick: got %b expected 1", tick); end
    while (cyc < 24) begin
      step();
      et = (cyc % 4 == 0);
      e  = 3'b100;
      checks++; if (led !== e) begin errors++; $display("FAIL simul_led c%0d: got %b expected %b", cyc, led, e); end
      checks++; if (tick !== et) begin errors++; $display("FAIL simul_tick c%0d: got %b expected %b", cyc, tick, et); end
    end
  endtask

  task automatic test_reset_mid();
    logic et;
    do_reset();
    sel = 3'b111;
    cfg_write(2'd0, MODE_PWM, 2'd2);
    cfg_write(2'd1, MODE_PWM, 2'd2);
    cfg_write(2'd2, MODE_PWM, 2'd2);
    while (cyc < 8) step();
    checks++; if (led !== 3'b111) begin errors++; $display("FAIL mid_pre_led: got %b expected 111", led); end
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL mid_pre_tick: got %b expected 1", tick); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (led !== 3'b000) begin errors++; $display("FAIL mid_async_led: got %b expected 000", led); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL mid_async_tick: got %b expected 0", tick); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    // Channels must be back in ON: PWM duty 2 would drop led in cycles 9..16.
    while (cyc < 16) begin
      step();
      et = (cyc % 4 == 0);
      checks++; if (led !== 3'b111) begin errors++; $display("FAIL mid_post_led c%0d: got %b expected 111", cyc, led); end
      checks++; if (tick !== et) begin errors++; $display("FAIL mid_post_tick c%0d: got %b expected %b", cyc, tick, et); end
    end
  endtask

  initial begin
    test_reset();
    test_blink();
    test_pwm();
    test_err_off();
    test_gate_simul();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
